// File: rtl/tick_gen_scan.sv
// tick_gen_scan: single-clock timebase for the stopwatch.
// This block produces one-cycle clock-enable ticks in the clk domain, so no
// derived or ripple clocks are needed.
//   Channel A (cnt_tick):
//     - Drives the digit counters.
//     - Gated by run; cleared by clr.
//   Channel B (scan_tick):
//     - Free-running.
//     - Steps digit_sel/digit_oh so the display can be multiplexed.
module tick_gen_scan #(
  parameter  int CNT_DIV    = 100000,
  parameter  int SCAN_DIV   = 25000,
  parameter  int NUM_DIGITS = 4,
  localparam int CW = $clog2(CNT_DIV    > 1 ? CNT_DIV    : 2),
  localparam int SW = $clog2(SCAN_DIV   > 1 ? SCAN_DIV   : 2),
  localparam int DW = $clog2(NUM_DIGITS > 1 ? NUM_DIGITS : 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clr,
  output logic                  cnt_tick,
  output logic                  scan_tick,
  output logic [DW-1:0]         digit_sel,
  output logic [NUM_DIGITS-1:0] digit_oh
);

  // Degenerate dividers or digit counts make no sense; stop elaboration.
  if (CNT_DIV < 1) begin : g_bad_cnt_div
    $error("tick_gen_scan: CNT_DIV must be >= 1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("tick_gen_scan: SCAN_DIV must be >= 1");
  end
  if (NUM_DIGITS < 1) begin : g_bad_num_digits
    $error("tick_gen_scan: NUM_DIGITS must be >= 1");
  end

  // Terminal values.
  // The prescalers wrap on equality, so they never exceed DIV-1.
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_pre_q,  cnt_pre_d;
  logic [SW-1:0]         scan_pre_q, scan_pre_d;
  logic                  cnt_tick_d, scan_tick_d;
  logic [DW-1:0]         digit_sel_d;
  logic [NUM_DIGITS-1:0] digit_oh_d;
  logic                  scan_wrap;

  // Count channel next state.
  // Priority: clr beats run; a paused prescaler keeps its phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // otherwise a branch that skips it infers a latch.
    cnt_pre_d  = cnt_pre_q;
    cnt_tick_d = 1'b0;
    if (clr) begin
      cnt_pre_d = '0;
    end else if (run) begin
      if (cnt_pre_q == CNT_LAST) begin
        cnt_pre_d  = '0;
        cnt_tick_d = 1'b1;
      end else begin
        cnt_pre_d = cnt_pre_q + CW'(1);
      end
    end
  end

  // Scan channel next state.
  // It always runs and ignores run/clr. digit_sel advances on the same
  // edge that raises scan_tick.
  always_comb begin
    scan_wrap   = (scan_pre_q == SCAN_LAST);
    scan_pre_d  = scan_wrap ? '0 : scan_pre_q + SW'(1);
    scan_tick_d = scan_wrap;
    digit_sel_d = digit_sel;
    if (scan_wrap) begin
      // Explicit wrap so non-power-of-two digit counts never reach NUM_DIGITS.
      digit_sel_d = (digit_sel == DIG_LAST) ? '0 : digit_sel + DW'(1);
    end
    // Decoded from the next index, so the registered one-hot tracks digit_sel.
    digit_oh_d = NUM_DIGITS'(1) << digit_sel_d;
  end

  // State and output registers.
  // Synchronous reset overrides run and clr. Every output comes from a flop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that all flops
    // sample the same pre-edge values regardless of statement order.
    if (reset) begin
      cnt_pre_q  <= '0;
      scan_pre_q <= '0;
      cnt_tick   <= 1'b0;
      scan_tick  <= 1'b0;
      digit_sel  <= '0;
      digit_oh   <= NUM_DIGITS'(1);
    end else begin
      cnt_pre_q  <= cnt_pre_d;
      scan_pre_q <= scan_pre_d;
      cnt_tick   <= cnt_tick_d;
      scan_tick  <= scan_tick_d;
      digit_sel  <= digit_sel_d;
      digit_oh   <= digit_oh_d;
    end
  end

endmodule

// File: tb/tb_tick_gen_scan.sv
// Testbench for tick_gen_scan. Two instances share the same inputs:
//   - dut:  CNT_DIV=4, SCAN_DIV=2, NUM_DIGITS=3
//   - dut1: CNT_DIV=1, SCAN_DIV=1, NUM_DIGITS=1
// Each step drives the inputs at negedge and pushes the predicted
// post-edge outputs onto a queue. The entry is popped and compared 1 ns
// after the next posedge.
module tb_tick_gen_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic       cnt_tick, scan_tick;
  logic [1:0] digit_sel;
  logic [2:0] digit_oh;
  logic       cnt_tick1, scan_tick1;
  logic [0:0] digit_sel1;
  logic [0:0] digit_oh1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       ct, st;
    int         sel;
    logic [2:0] oh;
    logic       ct1, st1;
  } exp_t;

  exp_t exp_q[$];

  // Model state: tick cadence is derived from edge counts, not a prescaler.
  int run_edges;   // run=1 edges since the last reset/clr
  int all_edges;   // non-reset edges since the last reset

  always #5 clk = ~clk;

  tick_gen_scan #(.CNT_DIV(4), .SCAN_DIV(2), .NUM_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .run(run), .clr(clr),
    .cnt_tick(cnt_tick), .scan_tick(scan_tick),
    .digit_sel(digit_sel), .digit_oh(digit_oh)
  );

  tick_gen_scan #(.CNT_DIV(1), .SCAN_DIV(1), .NUM_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .clr(clr),
    .cnt_tick(cnt_tick1), .scan_tick(scan_tick1),
    .digit_sel(digit_sel1), .digit_oh(digit_oh1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive, predict, advance, compare.
  task automatic step(input logic r, input logic rn, input logic c, input string tag);
    exp_t e;
    int   scan_cnt;
    @(negedge clk);
    reset = r;
    run   = rn;
    clr   = c;
    if (r) begin
      run_edges = 0;
      all_edges = 0;
      e.ct  = 1'b0;
      e.st  = 1'b0;
      e.ct1 = 1'b0;
      e.st1 = 1'b0;
    end else begin
      all_edges++;
      if (c) begin
        run_edges = 0;
        e.ct = 1'b0;
      end else if (rn) begin
        run_edges++;
        e.ct = (run_edges % 4 == 0);
      end else begin
        e.ct = 1'b0;
      end
      e.st  = (all_edges % 2 == 0);
      e.ct1 = rn && !c;
      e.st1 = 1'b1;
    end
    scan_cnt = all_edges / 2;
    e.sel = scan_cnt % 3;
    e.oh  = 3'b001 << e.sel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cnt_tick"},   32'(cnt_tick),   32'(e.ct));
      check({tag, "_scan_tick"},  32'(scan_tick),  32'(e.st));
      check({tag, "_digit_sel"},  32'(digit_sel),  32'(e.sel));
      check({tag, "_digit_oh"},   32'(digit_oh),   32'(e.oh));
      check({tag, "_cnt_tick1"},  32'(cnt_tick1),  32'(e.ct1));
      check({tag, "_scan_tick1"}, 32'(scan_tick1), 32'(e.st1));
      check({tag, "_digit_sel1"}, 32'(digit_sel1), 32'd0);
      check({tag, "_digit_oh1"},  32'(digit_oh1),  32'd1);
    end
  endtask

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    run_edges = 0;
    all_edges = 0;

    // 1: reset two cycles, then run. cnt_tick at 4,8,12; scan_tick at 2,4,6.
    step(1, 0, 0, "t1_reset");
    step(1, 1, 0, "t1_reset");
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 0, "t1_run");
      check("t1_cnt_cadence",  32'(cnt_tick),  32'(k % 4 == 0));
      check("t1_scan_cadence", 32'(scan_tick), 32'(k % 2 == 0));
    end

    // 2: digit scan. Walk further and confirm the index never passes 2.
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, "t2_scan");
      check("t2_sel_range", 32'(digit_sel < 2'd3), 32'd1);
    end

    // 3: clr to align, run 2 edges, pause 10, resume.
    // The tick must land on the 2nd resume edge.
    step(0, 0, 1, "t3_clr");
    step(0, 1, 0, "t3_run");
    step(0, 1, 0, "t3_run");
    for (int k = 0; k < 10; k++) step(0, 0, 0, "t3_pause");
    step(0, 1, 0, "t3_resume1");
    check("t3_no_tick_early", 32'(cnt_tick), 32'd0);
    step(0, 1, 0, "t3_resume2");
    check("t3_tick_after_2", 32'(cnt_tick), 32'd1);

    // 4: bring cnt_pre to 3, then clr+run together.
    // Expect no tick; the next tick comes 4 edges later.
    step(0, 0, 1, "t4_clr");
    for (int k = 0; k < 3; k++) step(0, 1, 0, "t4_run");
    step(0, 1, 1, "t4_clr_run");
    check("t4_clr_wins", 32'(cnt_tick), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, "t4_after");
      check("t4_tick_4_later", 32'(cnt_tick), 32'(k == 4));
    end

    // 5: reach cnt_pre=2 and digit_sel=2, then reset mid-period.
    step(1, 0, 0, "t5_reset");
    step(0, 0, 0, "t5_idle");
    step(0, 0, 0, "t5_idle");
    step(0, 1, 0, "t5_run");
    step(0, 1, 0, "t5_run");
    check("t5_sel_before", 32'(digit_sel), 32'd2);
    step(1, 1, 0, "t5_reset_mid");
    check("t5_oh_after_reset", 32'(digit_oh), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, "t5_restart");
      check("t5_restart_tick", 32'(cnt_tick), 32'(k == 4));
    end

    // 6: divide-by-one instance ticks on every run edge.
    // It stays silent on pause and on clr.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, "t6_run");
      check("t6_cnt1_every", 32'(cnt_tick1), 32'd1);
    end
    step(0, 0, 0, "t6_pause");
    check("t6_cnt1_paused", 32'(cnt_tick1), 32'd0);
    step(0, 1, 1, "t6_clr");
    check("t6_cnt1_clr", 32'(cnt_tick1), 32'd0);
    step(0, 1, 0, "t6_run_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
